// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch sequencer for the single-issue MIPS core.
// Owns the PC. Issues one word fetch at a time over imem_req/imem_ack and holds
// the returned word for decode on instr_valid/instr_ready. Selects the next PC
// (jump, taken branch or sequential) when decode accepts the held word.
// Optional build macro: PERF_CNT_EN adds retired/redirect/stall counters.
// Without it the counter ports are tied to zero.
//
// state      | meaning
// FETCH_IDLE | just out of reset, no request outstanding
// FETCH      | imem_req high, imem_addr = pc, waiting for imem_ack
// HOLD       | instr/instr_pc presented to decode, waiting for instr_ready
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        branch_sel,
    input  logic        zero,
    input  logic        jump_sel,
    output logic [31:0] retired_cnt,
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH      = 2'd1,
        HOLD       = 2'd2
    } fetchState_t;

    fetchState_t state;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] branchOffset;
    logic [31:0] nextPc;
    logic        handover;

    assign imem_addr = pc;
    assign handover  = instr_valid & instr_ready;

    // Next-PC select for the held instruction; jump takes priority over branch.
    always_comb begin
        pcPlus4      = instr_pc + 32'd4;
        branchOffset = {{14{instr[15]}}, instr[15:0], 2'b00};
        if (jump_sel) begin
            nextPc = {pcPlus4[31:28], instr[25:0], 2'b00};
        end else if (branch_sel && zero) begin
            nextPc = pcPlus4 + branchOffset;
        end else begin
            nextPc = pcPlus4;
        end
    end

    // Fetch/hold sequencer with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH_IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (handover) begin
                        pc          <= nextPc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state       <= FETCH_IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic redirect;

    assign redirect = jump_sel | (branch_sel & zero);

    // Performance counters, wrapping modulo 2^32, updated with the event edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt  <= 32'h0;
            redirect_cnt <= 32'h0;
            stall_cnt    <= 32'h0;
        end else begin
            if (handover) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
            if (handover && redirect) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
            if (instr_valid && !instr_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`else
    assign retired_cnt  = 32'h0;
    assign redirect_cnt = 32'h0;
    assign stall_cnt    = 32'h0;
`endif

endmodule
